// File: rtl/reg_exec_unit_if.sv
// Instruction handshake, register-bank bus and retire status
// between a producer/bank and reg_exec_unit.
interface reg_exec_unit_if #(
   parameter int DW = 8,
   parameter int AW = 3
);
   logic          instr_valid;
   logic          instr_ready;
   logic [15:0]   instr;
   logic [AW-1:0] rf_add1;
   logic [AW-1:0] rf_add2;
   logic [DW-1:0] rf_in;
   logic          rf_we;
   logic [DW-1:0] rf_out1;
   logic [DW-1:0] rf_out2;
   logic          done;
   logic [DW-1:0] result;
   logic          flag_z;
   logic          flag_c;
   logic          illegal;

   modport master (
      output instr_valid, instr, rf_out1, rf_out2,
      input  instr_ready, rf_add1, rf_add2, rf_in, rf_we,
      input  done, result, flag_z, flag_c, illegal
   );

   modport slave (
      input  instr_valid, instr, rf_out1, rf_out2,
      output instr_ready, rf_add1, rf_add2, rf_in, rf_we,
      output done, result, flag_z, flag_c, illegal
   );
endinterface

// File: rtl/reg_exec_unit.sv
// Three-cycle execute/write-back controller in front of the
// register bank: accept, read operands, execute and write back.
module reg_exec_unit #(
   parameter int DW = 8,
   parameter int AW = 3
) (
   input logic            clk,
   input logic            rst,
   reg_exec_unit_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_EXEC
   } state_e;

   state_e        state_q, state_d;
   logic [15:0]   instr_q, instr_d;
   logic [DW-1:0] a_q, a_d;
   logic [DW-1:0] b_q, b_d;
   logic [DW-1:0] res_q, res_d;
   logic          z_q, z_d;
   logic          c_q, c_d;
   logic          done_q, done_d;
   logic          ill_q, ill_d;

   logic [3:0]    op;
   logic [DW-1:0] alu_v;
   logic [DW:0]   sum;
   logic          alu_c, alu_wr, alu_zu, alu_cu, alu_ill;

   assign op = instr_q[15:12];

   always_comb begin
      alu_v   = '0;
      alu_c   = 1'b0;
      alu_wr  = 1'b0;
      alu_zu  = 1'b0;
      alu_cu  = 1'b0;
      alu_ill = 1'b0;
      sum     = {1'b0, a_q} + {1'b0, b_q};
      case (op)
         4'd0: ;
         4'd1: begin
            alu_v  = DW'(instr_q[7:0]);
            alu_wr = 1'b1;
         end
         4'd2: begin
            alu_v  = sum[DW-1:0];
            alu_c  = sum[DW];
            alu_wr = 1'b1;
            alu_zu = 1'b1;
            alu_cu = 1'b1;
         end
         4'd3: begin
            alu_v  = a_q - b_q;
            alu_c  = a_q < b_q;
            alu_wr = 1'b1;
            alu_zu = 1'b1;
            alu_cu = 1'b1;
         end
         4'd4, 4'd5, 4'd6: begin
            alu_v  = (op == 4'd4) ? (a_q & b_q) :
                     (op == 4'd5) ? (a_q | b_q) : (a_q ^ b_q);
            alu_wr = 1'b1;
            alu_zu = 1'b1;
            alu_cu = 1'b1;
         end
         4'd7: begin
            alu_v  = b_q;
            alu_wr = 1'b1;
         end
         4'd8: begin
            alu_v  = a_q << 1;
            alu_c  = a_q[DW-1];
            alu_wr = 1'b1;
            alu_zu = 1'b1;
            alu_cu = 1'b1;
         end
         4'd9: begin
            alu_v  = a_q >> 1;
            alu_c  = a_q[0];
            alu_wr = 1'b1;
            alu_zu = 1'b1;
            alu_cu = 1'b1;
         end
         default: alu_ill = 1'b1;
      endcase
   end

   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      z_d     = z_q;
      c_d     = c_q;
      done_d  = 1'b0;
      ill_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.instr_valid) begin
               instr_d = bus.instr;
               state_d = S_READ;
            end
         end
         S_READ: begin
            a_d     = bus.rf_out1;
            b_d     = bus.rf_out2;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            ill_d   = alu_ill;
            if (alu_wr) res_d = alu_v;
            if (alu_zu) z_d = (alu_v == '0);
            if (alu_cu) c_d = alu_c;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         instr_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
         done_q  <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         z_q     <= z_d;
         c_q     <= c_d;
         done_q  <= done_d;
         ill_q   <= ill_d;
      end
   end

   // Write is gated by rst so a reset cycle never corrupts the bank.
   assign bus.instr_ready = (state_q == S_IDLE);
   assign bus.rf_add1     = AW'(instr_q[11:9]);
   assign bus.rf_add2     = AW'(instr_q[8:6]);
   assign bus.rf_in       = (state_q == S_EXEC) ? alu_v : '0;
   assign bus.rf_we       = (state_q == S_EXEC) && alu_wr && !rst;
   assign bus.done        = done_q;
   assign bus.result      = res_q;
   assign bus.flag_z      = z_q;
   assign bus.flag_c      = c_q;
   assign bus.illegal     = ill_q;
endmodule
